// File: rtl/vga_bounce_box_if.sv
// Pixel-stream bundle between the VGA timing generator and the bounce-box colour source.
interface vga_bounce_box_if;
  logic [10:0] pixel_x;
  logic [9:0]  pixel_y;
  logic        pixel_valid;
  logic        frame_start;
  logic        pause;
  logic        red;
  logic        green;
  logic        blue;
  logic [15:0] bounce_count;
  logic [7:0]  corner_count;

  // Timing generator side: drives coordinates and strobes, receives colour.
  modport master (
    output pixel_x, pixel_y, pixel_valid, frame_start, pause,
    input  red, green, blue, bounce_count, corner_count
  );

  // Colour source side.
  modport slave (
    input  pixel_x, pixel_y, pixel_valid, frame_start, pause,
    output red, green, blue, bounce_count, corner_count
  );
endinterface

// File: rtl/vga_bounce_box.sv
// Bouncing square over a white background: per-frame motion with edge clamping,
// colour change on every bounce, and one-cycle registered pixel colour output.
module vga_bounce_box #(
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 600,
  parameter int BOX_SIZE = 100,
  parameter int STEP_X   = 2,
  parameter int STEP_Y   = 1,
  parameter int INIT_X   = 100,
  parameter int INIT_Y   = 100
) (
  input logic              CLOCK_50,
  input logic              RESET,
  vga_bounce_box_if.slave  bus
);

  localparam logic [11:0] LP_X_MAX  = 12'(H_ACTIVE - BOX_SIZE);
  localparam logic [11:0] LP_Y_MAX  = 12'(V_ACTIVE - BOX_SIZE);
  localparam logic [11:0] LP_STEP_X = 12'(STEP_X);
  localparam logic [11:0] LP_STEP_Y = 12'(STEP_Y);
  localparam logic [11:0] LP_BOX    = 12'(BOX_SIZE);
  localparam logic [11:0] LP_INIT_X = 12'(INIT_X);
  localparam logic [11:0] LP_INIT_Y = 12'(INIT_Y);

  // Box position is held in 12 bits so edge arithmetic never wraps.
  logic [11:0] r_box_x;
  logic [11:0] r_box_y;
  logic        r_dir_left;
  logic        r_dir_up;
  logic [2:0]  r_colour_idx;
  logic        r_red;
  logic        r_green;
  logic        r_blue;
  logic [15:0] r_bounce_count;
  logic [7:0]  r_corner_count;

  logic [11:0] w_px;
  logic [11:0] w_py;
  logic        w_in_box;
  logic [2:0]  w_colour;
  logic        w_update;
  logic [11:0] w_next_x;
  logic [11:0] w_next_y;
  logic        w_next_left;
  logic        w_next_up;
  logic        w_hit_x;
  logic        w_hit_y;
  logic [2:0]  w_next_idx;

  assign w_px     = {1'b0, bus.pixel_x};
  assign w_py     = {2'b00, bus.pixel_y};
  assign w_update = bus.frame_start & ~bus.pause;

  assign w_in_box = (w_px >= r_box_x) && (w_px < r_box_x + LP_BOX) &&
                    (w_py >= r_box_y) && (w_py < r_box_y + LP_BOX);

  // Colour table lookup, {red, green, blue}.
  always_comb begin
    w_colour = 3'b000;
    case (r_colour_idx)
      3'd0:    w_colour = 3'b100;
      3'd1:    w_colour = 3'b010;
      3'd2:    w_colour = 3'b001;
      3'd3:    w_colour = 3'b110;
      3'd4:    w_colour = 3'b011;
      3'd5:    w_colour = 3'b101;
      default: w_colour = 3'b000;
    endcase
  end

  // Horizontal step with clamping at either active-area edge.
  always_comb begin
    w_next_x    = r_box_x;
    w_next_left = r_dir_left;
    w_hit_x     = 1'b0;
    if (!r_dir_left) begin
      if (r_box_x + LP_STEP_X >= LP_X_MAX) begin
        w_next_x    = LP_X_MAX;
        w_next_left = 1'b1;
        w_hit_x     = 1'b1;
      end else begin
        w_next_x = r_box_x + LP_STEP_X;
      end
    end else begin
      if (r_box_x <= LP_STEP_X) begin
        w_next_x    = 12'd0;
        w_next_left = 1'b0;
        w_hit_x     = 1'b1;
      end else begin
        w_next_x = r_box_x - LP_STEP_X;
      end
    end
  end

  // Vertical step with clamping at either active-area edge.
  always_comb begin
    w_next_y  = r_box_y;
    w_next_up = r_dir_up;
    w_hit_y   = 1'b0;
    if (!r_dir_up) begin
      if (r_box_y + LP_STEP_Y >= LP_Y_MAX) begin
        w_next_y  = LP_Y_MAX;
        w_next_up = 1'b1;
        w_hit_y   = 1'b1;
      end else begin
        w_next_y = r_box_y + LP_STEP_Y;
      end
    end else begin
      if (r_box_y <= LP_STEP_Y) begin
        w_next_y  = 12'd0;
        w_next_up = 1'b0;
        w_hit_y   = 1'b1;
      end else begin
        w_next_y = r_box_y - LP_STEP_Y;
      end
    end
  end

  assign w_next_idx = (r_colour_idx == 3'd5) ? 3'd0 : r_colour_idx + 3'd1;

  // Per-frame motion and bounce bookkeeping; a corner counts as one bounce.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_box_x        <= LP_INIT_X;
      r_box_y        <= LP_INIT_Y;
      r_dir_left     <= 1'b0;
      r_dir_up       <= 1'b0;
      r_colour_idx   <= 3'd0;
      r_bounce_count <= 16'd0;
      r_corner_count <= 8'd0;
    end else if (w_update) begin
      r_box_x    <= w_next_x;
      r_box_y    <= w_next_y;
      r_dir_left <= w_next_left;
      r_dir_up   <= w_next_up;
      if (w_hit_x || w_hit_y) begin
        r_colour_idx   <= w_next_idx;
        r_bounce_count <= r_bounce_count + 16'd1;
      end
      if (w_hit_x && w_hit_y) begin
        r_corner_count <= r_corner_count + 8'd1;
      end
    end
  end

  // Registered pixel colour: black outside active video, box colour inside, white elsewhere.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      {r_red, r_green, r_blue} <= 3'b000;
    end else if (!bus.pixel_valid) begin
      {r_red, r_green, r_blue} <= 3'b000;
    end else if (w_in_box) begin
      {r_red, r_green, r_blue} <= w_colour;
    end else begin
      {r_red, r_green, r_blue} <= 3'b111;
    end
  end

  assign bus.red          = r_red;
  assign bus.green        = r_green;
  assign bus.blue         = r_blue;
  assign bus.bounce_count = r_bounce_count;
  assign bus.corner_count = r_corner_count;

endmodule
